psg_multi: RTL

//  Parametrised N-channel square-wave PSG: next generation of the two-channel tone unit.

---
 rtl/psg_multi_if.sv | 14 +
 rtl/psg_multi.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/psg_multi_if.sv
// CPU I/O bus view of the PSG register file: chip select, direction, address and
// both data directions. The CPU side is the master; the PSG is the slave.
interface psg_multi_if #(
  parameter int ADDR_W = 6
) ();
  logic              snd_cs;
  logic              cpu_rwn;
  logic [ADDR_W-1:0] AB;
  logic [7:0]        dbus_in;
  logic [7:0]        dbus_out;

  modport master (output snd_cs, cpu_rwn, AB, dbus_in, input dbus_out);
  modport slave  (input snd_cs, cpu_rwn, AB, dbus_in, output dbus_out);
endinterface

// File: rtl/psg_multi.sv
// N-channel square-wave PSG with per-channel stereo pan, length timer, volume envelope,
// a saturating registered L/R mixer and a mute-status readback register.
module psg_multi #(
  parameter int NUM_CH = 4,
  parameter int FREQ_W = 11,
  parameter int VOL_W  = 4,
  parameter int OUT_W  = 6,
  parameter int ADDR_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             frame_tick,
  psg_multi_if.slave       bus,
  output logic [OUT_W-1:0] L,
  output logic [OUT_W-1:0] R
);

  localparam int CH_W  = ADDR_W - 3;
  localparam int SUM_W = VOL_W + $clog2(NUM_CH) + 1;
  localparam int CMP_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
  localparam logic [CMP_W-1:0] OUT_MAX = CMP_W'((1 << OUT_W) - 1);

  typedef enum logic [2:0] {
    OFF_FREQ_LO = 3'd0,
    OFF_FREQ_HI = 3'd1,
    OFF_VDUTY   = 3'd2,
    OFF_LENGTH  = 3'd3,
    OFF_ENV     = 3'd4,
    OFF_PAN     = 3'd5
  } reg_off_e;

  // Per-channel state
  logic [FREQ_W-1:0] freq    [NUM_CH];
  logic [FREQ_W-1:0] cnt     [NUM_CH];
  logic [3:0]        phase   [NUM_CH];
  logic [VOL_W-1:0]  vol     [NUM_CH];
  logic [1:0]        duty    [NUM_CH];
  logic [7:0]        timer   [NUM_CH];
  logic [2:0]        env_per [NUM_CH];
  logic [2:0]        env_div [NUM_CH];
  logic [1:0]        pan     [NUM_CH];
  logic [NUM_CH-1:0] sw, ign, pend, mute, env_up;
  logic              sys_div;

  logic              wr_strobe, rd_strobe;
  logic [CH_W-1:0]   ch_sel;
  reg_off_e          reg_off;
  logic [NUM_CH-1:0] wr_ch;
  logic [NUM_CH-1:0] live;
  logic [7:0]        status;
  logic [3:0]        phase_nx   [NUM_CH];
  logic [3:0]        duty_dc    [NUM_CH];
  logic [2:0]        env_div_nx [NUM_CH];
  logic [VOL_W-1:0]  ch_out     [NUM_CH];
  logic [CMP_W-1:0]  sum_l, sum_r;

  assign wr_strobe = ce & bus.snd_cs & ~bus.cpu_rwn;
  assign rd_strobe = ce & bus.snd_cs & bus.cpu_rwn;
  assign ch_sel    = bus.AB[ADDR_W-1:3];
  assign reg_off   = reg_off_e'(bus.AB[2:0]);
  assign live      = ~mute;
  assign status    = 8'(live);

  // NOTE: combinational blocks use blocking '=' and give every output a default on
  // entry, so no path leaves a value held and no latch is inferred.
  always_comb begin
    wr_ch = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_ch[c]      = wr_strobe && (ch_sel == CH_W'(c));
      phase_nx[c]   = phase[c] + 4'd1;
      env_div_nx[c] = env_div[c] + 3'd1;
      ch_out[c]     = (sw[c] && (!mute[c] || ign[c])) ? vol[c] : '0;
      case (duty[c])
        2'd0:    duty_dc[c] = 4'd1;
        2'd1:    duty_dc[c] = 4'd3;
        2'd2:    duty_dc[c] = 4'd7;
        default: duty_dc[c] = 4'd11;
      endcase
    end
  end

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pan[c][0]) sum_l = sum_l + CMP_W'(ch_out[c]);
      if (pan[c][1]) sum_r = sum_r + CMP_W'(ch_out[c]);
    end
  end

  // NOTE: sequential state uses non-blocking '<=' only; the register bank is reset
  // explicitly because reset must leave no partial channel state behind.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sys_div      <= 1'b0;
      sw           <= '0;
      ign          <= '0;
      pend         <= '0;
      mute         <= '0;
      env_up       <= '0;
      bus.dbus_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        freq[c]    <= '0;
        cnt[c]     <= '0;
        phase[c]   <= '0;
        vol[c]     <= '0;
        duty[c]    <= '0;
        timer[c]   <= '0;
        env_per[c] <= '0;
        env_div[c] <= '0;
        pan[c]     <= '0;
      end
    end else if (ce) begin
      sys_div <= ~sys_div;
      if (rd_strobe) bus.dbus_out <= (bus.AB == '1) ? status : 8'd0;

      for (int c = 0; c < NUM_CH; c++) begin
        if (sys_div) begin
          if (cnt[c] == freq[c]) begin
            cnt[c]   <= '0;
            phase[c] <= phase_nx[c];
            if (phase_nx[c] == duty_dc[c])  sw[c] <= 1'b0;
            else if (phase_nx[c] == 4'd15)  sw[c] <= 1'b1;
          end else begin
            cnt[c] <= cnt[c] + FREQ_W'(1);
          end
        end

        if (frame_tick) begin
          if (timer[c] != 8'd0) timer[c] <= timer[c] - 8'd1;
          if (pend[c]) begin
            pend[c] <= 1'b0;
            mute[c] <= 1'b1;
          end
          if (timer[c] == 8'd1) pend[c] <= 1'b1;

          if (env_per[c] != 3'd0) begin
            if (env_div_nx[c] == env_per[c]) begin
              env_div[c] <= '0;
              if (env_up[c]) begin
                if (vol[c] != '1) vol[c] <= vol[c] + VOL_W'(1);
              end else if (vol[c] != '0) begin
                vol[c] <= vol[c] - VOL_W'(1);
              end
            end else begin
              env_div[c] <= env_div_nx[c];
            end
          end
        end

        // Register writes come last so they override a same-cycle tick or counter hit.
        if (wr_ch[c]) begin
          case (reg_off)
            OFF_FREQ_LO: begin
              freq[c][7:0] <= bus.dbus_in;
              cnt[c]       <= '0;
            end
            OFF_FREQ_HI: begin
              freq[c][FREQ_W-1:8] <= bus.dbus_in[FREQ_W-9:0];
              cnt[c]              <= '0;
            end
            OFF_VDUTY: begin
              vol[c]     <= VOL_W'(bus.dbus_in[3:0]);
              duty[c]    <= bus.dbus_in[5:4];
              ign[c]     <= bus.dbus_in[6];
              env_div[c] <= '0;
            end
            OFF_LENGTH: begin
              timer[c] <= bus.dbus_in;
              if (bus.dbus_in != 8'd0) begin
                mute[c] <= 1'b0;
                pend[c] <= 1'b0;
              end else begin
                pend[c] <= 1'b1;
              end
            end
            OFF_ENV: begin
              env_per[c] <= bus.dbus_in[2:0];
              env_up[c]  <= bus.dbus_in[3];
            end
            OFF_PAN: pan[c] <= bus.dbus_in[1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // The mixer runs every clock, independent of ce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      L <= '0;
      R <= '0;
    end else begin
      L <= (sum_l > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : sum_l[OUT_W-1:0];
      R <= (sum_r > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : sum_r[OUT_W-1:0];
    end
  end

endmodule
